tlb: RTL
========

TLB -- requirements
Module: tlb

Interface
REQ-001 TLBNUM, 16, number of entries; index width is 4 bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 s0_vpn2, s0_odd_page, s0_asid  input  19/1/8  fetch-side search key.
REQ-005 s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_multi  output  1/4/20/3/1/1/1  fetch-side search result.
REQ-006 s1_vpn2, s1_odd_page, s1_asid  input  19/1/8  data/TLBP search key.
REQ-007 s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_multi  output  1/4/20/3/1/1/1  data/TLBP search result.
REQ-008 we, wr_random, w_index  input  1/1/4  write strobe, use-random-index select (TLBWR), explicit index (TLBWI).
REQ-009 w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  input  19/8/1/20/3/1/1/20/3/1/1  write entry fields.
REQ-010 r_index  input  4  read index (TLBR).
REQ-011 r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  output  as write fields  entry at r_index.
REQ-012 wired  input  4  lower bound for random replacement.
REQ-013 wired_we  input  1  pulse when CP0 Wired is written.
REQ-014 random  output  4  current random replacement index.

Function
REQ-015 Storage SHALL be TLBNUM entries holding vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1.
REQ-016 Entry i SHALL match port k when vpn2[i]==sk_vpn2 and (g[i] or asid[i]==sk_asid); the match is independent of v bits.
REQ-017 sk_found SHALL be the OR of all matches; sk_index SHALL be the lowest matching index.
REQ-018 sk_multi SHALL be 1 when more than one entry matches.
REQ-019 On a hit, sk_pfn/c/d/v SHALL come from page 1 of sk_index when sk_odd_page=1, otherwise page 0.
REQ-020 On a miss, sk_index, sk_pfn, sk_c, sk_d and sk_v SHALL all be 0.
REQ-021 Search and read paths SHALL be combinational with zero-cycle latency.
REQ-022 When we=1, the entry at (wr_random ? random : w_index) SHALL be overwritten at the clock edge.
REQ-023 A written entry SHALL be visible on search and read ports from the next cycle; there is no same-cycle bypass.
REQ-024 r_* SHALL combinationally reflect the entry at r_index.
REQ-025 random SHALL update every cycle. Next value is TLBNUM-1 when wired_we=1 or random<=wired; otherwise next value is random-1.
REQ-026 If wired>=TLBNUM-1, random SHALL hold at TLBNUM-1.
REQ-027 A TLBWR write (we=1, wr_random=1) SHALL use the pre-edge value of random; random still advances on that edge.
REQ-028 Simultaneous searches on both ports SHALL be independent, including when both key the same entry.

Reset
REQ-029 While reset=1, every field of every entry SHALL be cleared to 0 and random SHALL be set to TLBNUM-1. reset takes priority over we and wired_we.
REQ-030 After reset, search with key vpn2=0, asid=0 SHALL hit all 16 entries with s_index=0 and s_multi=1. Search with any nonzero vpn2 SHALL miss.

Verification
REQ-031 Write/search: write idx 5 {vpn2=0x12345, asid=0x3, g=0, pfn1=0xABCDE, v1=1}; next cycle s1 {0x12345, odd=1, asid=0x3} -> found=1, index=5, pfn=0xABCDE, v=1. The same search with asid=0x4 -> found=0, all result fields 0.
REQ-032 Global bypass: write idx 2 with g=1, vpn2=0x00400; search asid=0xFF -> found=1, index=2. Write idx 9 with the same vpn2 -> multi=1, index=2.
REQ-033 No bypass: we=1 to idx 7 with a new vpn2 while s0 searches that vpn2 in the same cycle -> miss that cycle, hit with index=7 the next cycle.
REQ-034 Random: after reset with wired=3, random sequence is 15,14,...,3,15. Pulse wired_we when random=8 -> random=15 next cycle. TLBWR issued when random=10 -> entry 10 written.
REQ-035 Read port: write idx 15; r_index=15 next cycle -> r_* equal the written fields. Assert reset with we=1 -> entry stays 0 and random=15.

Source files
------------

// File: rtl/tlb_if.sv
// Bus bundle for the TLB: two search ports, a write port and a read port.
// The TLB itself attaches through the slave modport; the requester uses master.
interface tlb_if;
    logic [18:0] s0_vpn2;
    logic        s0_odd_page;
    logic [7:0]  s0_asid;
    logic        s0_found;
    logic [3:0]  s0_index;
    logic [19:0] s0_pfn;
    logic [2:0]  s0_c;
    logic        s0_d;
    logic        s0_v;
    logic        s0_multi;

    logic [18:0] s1_vpn2;
    logic        s1_odd_page;
    logic [7:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic [19:0] s1_pfn;
    logic [2:0]  s1_c;
    logic        s1_d;
    logic        s1_v;
    logic        s1_multi;

    logic        we;
    logic        wr_random;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g;
    logic [19:0] w_pfn0;
    logic [2:0]  w_c0;
    logic        w_d0;
    logic        w_v0;
    logic [19:0] w_pfn1;
    logic [2:0]  w_c1;
    logic        w_d1;
    logic        w_v1;

    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0;
    logic [2:0]  r_c0;
    logic        r_d0;
    logic        r_v0;
    logic [19:0] r_pfn1;
    logic [2:0]  r_c1;
    logic        r_d1;
    logic        r_v1;

    modport slave (
        input  s0_vpn2, s0_odd_page, s0_asid,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_multi,
        input  s1_vpn2, s1_odd_page, s1_asid,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_multi,
        input  we, wr_random, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        output r_pfn1, r_c1, r_d1, r_v1
    );

    modport master (
        output s0_vpn2, s0_odd_page, s0_asid,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_multi,
        output s1_vpn2, s1_odd_page, s1_asid,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_multi,
        output we, wr_random, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
        input  r_pfn1, r_c1, r_d1, r_v1
    );
endinterface

// File: rtl/tlb.sv
// 16-entry fully associative MIPS-style TLB with dual combinational search,
// indexed/random write, combinational read and a Wired-bounded random counter.
module tlb (
    input  logic       clk,
    input  logic       reset,
    tlb_if.slave       bus,
    input  logic [3:0] wired,
    input  logic       wired_we,
    output logic [3:0] random
);
    localparam int         TLBNUM   = 16;
    localparam logic [3:0] LAST_IDX = 4'd15;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    entry_t     entry_q [TLBNUM];
    entry_t     entry_d [TLBNUM];
    logic [3:0] random_q;
    logic [3:0] random_d;
    logic [3:0] w_idx;
    entry_t     w_entry;

    logic [TLBNUM-1:0] match0;
    logic [TLBNUM-1:0] match1;
    logic [3:0]        idx0;
    logic [3:0]        idx1;
    entry_t            hit0;
    entry_t            hit1;
    entry_t            rd;

    function automatic logic [3:0] lowest_set(input logic [TLBNUM-1:0] m);
        lowest_set = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = 4'(i);
        end
    endfunction

    // TLBWR samples random before the edge, so the write target uses random_q.
    always_comb begin
        w_entry = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                    pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
                    pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};
        w_idx   = bus.wr_random ? random_q : bus.w_index;
        entry_d = entry_q;
        if (bus.we) entry_d[w_idx] = w_entry;
    end

    always_comb begin
        if (wired_we || random_q <= wired) random_d = LAST_IDX;
        else                               random_d = random_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
            random_q <= LAST_IDX;
        end else begin
            entry_q  <= entry_d;
            random_q <= random_d;
        end
    end

    assign random = random_q;

    // Validity bits deliberately play no part in matching.
    always_comb begin
        match0 = '0;
        match1 = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            match0[i] = (entry_q[i].vpn2 == bus.s0_vpn2) &&
                        (entry_q[i].g || entry_q[i].asid == bus.s0_asid);
            match1[i] = (entry_q[i].vpn2 == bus.s1_vpn2) &&
                        (entry_q[i].g || entry_q[i].asid == bus.s1_asid);
        end
    end

    always_comb begin
        idx0 = lowest_set(match0);
        idx1 = lowest_set(match1);
        hit0 = entry_q[idx0];
        hit1 = entry_q[idx1];

        bus.s0_found = |match0;
        bus.s0_index = idx0;
        bus.s0_multi = (match0 & (match0 - 16'd1)) != '0;
        bus.s0_pfn   = '0;
        bus.s0_c     = '0;
        bus.s0_d     = 1'b0;
        bus.s0_v     = 1'b0;
        if (bus.s0_found) begin
            bus.s0_pfn = bus.s0_odd_page ? hit0.pfn1 : hit0.pfn0;
            bus.s0_c   = bus.s0_odd_page ? hit0.c1   : hit0.c0;
            bus.s0_d   = bus.s0_odd_page ? hit0.d1   : hit0.d0;
            bus.s0_v   = bus.s0_odd_page ? hit0.v1   : hit0.v0;
        end

        bus.s1_found = |match1;
        bus.s1_index = idx1;
        bus.s1_multi = (match1 & (match1 - 16'd1)) != '0;
        bus.s1_pfn   = '0;
        bus.s1_c     = '0;
        bus.s1_d     = 1'b0;
        bus.s1_v     = 1'b0;
        if (bus.s1_found) begin
            bus.s1_pfn = bus.s1_odd_page ? hit1.pfn1 : hit1.pfn0;
            bus.s1_c   = bus.s1_odd_page ? hit1.c1   : hit1.c0;
            bus.s1_d   = bus.s1_odd_page ? hit1.d1   : hit1.d0;
            bus.s1_v   = bus.s1_odd_page ? hit1.v1   : hit1.v0;
        end
    end

    always_comb begin
        rd         = entry_q[bus.r_index];
        bus.r_vpn2 = rd.vpn2;
        bus.r_asid = rd.asid;
        bus.r_g    = rd.g;
        bus.r_pfn0 = rd.pfn0;
        bus.r_c0   = rd.c0;
        bus.r_d0   = rd.d0;
        bus.r_v0   = rd.v0;
        bus.r_pfn1 = rd.pfn1;
        bus.r_c1   = rd.c1;
        bus.r_d1   = rd.d1;
        bus.r_v1   = rd.v1;
    end
endmodule
